riscv_regfile_scoreboard: RTL and testbench
===========================================

// Module: riscv_regfile_scoreboard
// PURPOSE
//  Tracks in-flight writes to the 32x32 integer register file and gates instruction
//  issue on RAW/WAW hazards. Sits between decode/issue and the register file:
//  - sets a busy bit per destination register on issue;
//  - clears it when writeback retires the write.
//  Also bounds the number of outstanding writes and flags protocol errors.
// PARAMETERS
//  MAX_INFLIGHT  4  maximum outstanding register writes (1..31); issue stalls when reached
//  WB_BYPASS     1  1: a register cleared by writeback in the current cycle counts as
//                   not busy for issue; 0: busy until the clear is registered
// PORTS
//  clk_i             in   1   clock, all state on rising edge
//  rst_i             in   1   asynchronous reset, active-high
//  Issue_valid_i     in   1   decode presents an instruction this cycle
//  Issue_rs1_i       in   5   source register A address
//  Issue_rs2_i       in   5   source register B address
//  Issue_rs1_used_i  in   1   instruction reads rs1
//  Issue_rs2_used_i  in   1   instruction reads rs2
//  Issue_rd_i        in   5   destination register address
//  Issue_rd_wen_i    in   1   instruction writes rd
//  Issue_ready_o     out  1   no hazard: instruction may issue this cycle
//  Wb_valid_i        in   1   writeback retires a register write this cycle
//  Wb_rd_i           in   5   register being written back
//  Flush_i           in   1   pipeline drained/flushed: discard all tracking
//  Busy_o            out  32  busy bit per register (bit 0 always 0)
//  Inflight_o        out  6   number of outstanding writes
//  Err_o             out  1   sticky protocol error
// BEHAVIOUR
//  - Reset (async, immediate): Busy_o=0, Inflight_o=0, Err_o=0.
//    Issue_ready_o then follows the combinational rule with empty state.
//  - Effective busy of register r:
//      busy[r] & ~(WB_BYPASS & Wb_valid_i & Wb_rd_i==r & r!=0).
//  - Issue_ready_o (combinational) = ~Flush_i & none of:
//      rs1_used & effbusy[rs1];
//      rs2_used & effbusy[rs2];
//      rd_wen & rd!=0 & effbusy[rd]          (WAW);
//      rd_wen & rd!=0 & Inflight_o==MAX_INFLIGHT & ~wb_clear.
//  - Issue_ready_o does not depend on Issue_valid_i.
//  - Fire = Issue_valid_i & Issue_ready_o. On fire with rd_wen & rd!=0, the next edge
//    sets busy[rd].
//  - x0 is never tracked: issue to x0 or with rd_wen=0 changes no state.
//  - wb_clear = Wb_valid_i & Wb_rd_i!=0 & busy[Wb_rd_i]. On wb_clear the next edge
//    clears busy[Wb_rd_i].
//  - Wb_valid_i to a non-busy register other than x0: state unchanged, Err_o set (sticky
//    until reset). Wb to x0 is ignored without error.
//  - Same edge, fire sets busy[X] and wb_clear clears busy[X] (WB_BYPASS=1 only):
//    busy[X] ends at 1, Inflight unchanged.
//  - Inflight_o next = Inflight + set - wb_clear. It never exceeds MAX_INFLIGHT and
//    never wraps below 0.
//  - Inflight_o always equals popcount(Busy_o). A register with busy=1 is never set
//    again, which the WAW rule guarantees.
//  - Flush_i (synchronous, highest priority):
//    - next edge: Busy_o=0, Inflight_o=0; Err_o is kept;
//    - same-cycle issue and wb are discarded, no error is raised.
//  - Latency: set or clear is visible on Busy_o one cycle after the event. Readiness
//    sees a same-cycle writeback only when WB_BYPASS=1.
//  - Reset asserted mid-operation clears all state immediately.
// TESTING
//  1. Reset, then issue rd=x5 -> Busy_o=0x20, Inflight_o=1. Next rs1=x5, rs1_used=1 ->
//     Issue_ready_o=0 until Wb_rd_i=5 (WB_BYPASS=1: ready=1 in the wb cycle itself).
//  2. Issue rd=x1,x2,x3,x4 (MAX_INFLIGHT=4) -> Inflight_o=4. A 5th issue with rd=x6 ->
//     ready=0. Issue with rd_wen=0 and no source hazard -> ready=1.
//  3. Issue rd=x0 with rd_wen=1 -> Busy_o=0, Inflight_o=0. Wb_rd_i=0 -> Err_o stays 0.
//  4. busy[7]=1; same cycle issue rd=7 and Wb_rd_i=7 -> Busy_o[7]=1, Inflight_o unchanged.
//     WAW: rd=7 while busy with no wb -> ready=0.
//  5. Wb_rd_i=9 while busy[9]=0 -> Err_o=1, held. Flush_i -> Busy_o=0, Inflight_o=0,
//     Err_o still 1.
//  6. Assert rst_i between clock edges with Inflight_o=3 -> all outputs 0 before the next
//     edge. Random issue/wb check: Inflight_o == popcount(Busy_o) every cycle.

Source files
------------

// File: rtl/riscv_regfile_scoreboard.sv
// riscv_regfile_scoreboard
//   Tracks in-flight writes to the 32x32 integer register file and gates instruction
//   issue on RAW/WAW hazards. A busy bit is set for the destination register when an
//   instruction issues and cleared when writeback retires that write. The number of
//   outstanding writes is bounded, and protocol errors are flagged.
//
// Parameters
//   MAX_INFLIGHT : maximum outstanding register writes (1..31)
//   WB_BYPASS    : 1 = a register retired by writeback this cycle counts as free for issue
//
// Ports
//   clk_i, rst_i                    : clock, asynchronous active-high reset
//   Issue_valid_i                   : decode presents an instruction
//   Issue_rs1_i/_rs2_i, *_used_i    : source registers and whether they are read
//   Issue_rd_i, Issue_rd_wen_i      : destination register and write enable
//   Issue_ready_o                   : no hazard, the instruction may issue this cycle
//   Wb_valid_i, Wb_rd_i             : writeback retires a write to Wb_rd_i
//   Flush_i                         : discard all tracking (error flag is kept)
//   Busy_o                          : busy bit per register (bit 0 always 0)
//   Inflight_o                      : number of outstanding writes
//   Err_o                           : sticky protocol error
module riscv_regfile_scoreboard #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter bit          WB_BYPASS    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Issue_valid_i,
  input  logic [4:0]  Issue_rs1_i,
  input  logic [4:0]  Issue_rs2_i,
  input  logic        Issue_rs1_used_i,
  input  logic        Issue_rs2_used_i,
  input  logic [4:0]  Issue_rd_i,
  input  logic        Issue_rd_wen_i,
  output logic        Issue_ready_o,
  input  logic        Wb_valid_i,
  input  logic [4:0]  Wb_rd_i,
  input  logic        Flush_i,
  output logic [31:0] Busy_o,
  output logic [5:0]  Inflight_o,
  output logic        Err_o
);

  logic [31:0] busyQ, busyD;
  logic [5:0]  inflightQ, inflightD;
  logic        errQ, errD;

  logic        wbHit;
  logic        wbClear;
  logic        wbErr;
  logic [31:0] wbMask;
  logic [31:0] setMask;
  logic [31:0] effBusy;
  logic        rdTracked;
  logic        full;
  logic        hazard;
  logic        ready;
  logic        setOne;

  always_comb begin
    wbHit     = Wb_valid_i && (Wb_rd_i != 5'd0);
    wbClear   = wbHit && busyQ[Wb_rd_i];
    // Writeback to a register nobody is waiting on is a protocol violation.
    wbErr     = wbHit && !busyQ[Wb_rd_i];
    wbMask    = wbClear ? (32'd1 << Wb_rd_i) : 32'd0;

    // With bypass, a register retiring this cycle is already free for issue.
    effBusy   = WB_BYPASS ? (busyQ & ~wbMask) : busyQ;

    rdTracked = Issue_rd_wen_i && (Issue_rd_i != 5'd0);
    full      = (inflightQ == 6'(MAX_INFLIGHT));

    hazard    = (Issue_rs1_used_i && effBusy[Issue_rs1_i])
             || (Issue_rs2_used_i && effBusy[Issue_rs2_i])
             || (rdTracked && effBusy[Issue_rd_i])
             || (rdTracked && full && !wbClear);
    ready     = !Flush_i && !hazard;

    setOne    = Issue_valid_i && ready && rdTracked;
    setMask   = setOne ? (32'd1 << Issue_rd_i) : 32'd0;
  end

  always_comb begin
    busyD     = busyQ;
    inflightD = inflightQ;
    errD      = errQ;
    if (Flush_i) begin
      busyD     = 32'd0;
      inflightD = 6'd0;
    end else begin
      // Set after clear: a same-cycle retire and re-issue of one register leaves it busy.
      busyD     = (busyQ & ~wbMask) | setMask;
      inflightD = inflightQ + {5'd0, setOne} - {5'd0, wbClear};
      errD      = errQ | wbErr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busyQ     <= 32'd0;
      inflightQ <= 6'd0;
      errQ      <= 1'b0;
    end else begin
      busyQ     <= busyD;
      inflightQ <= inflightD;
      errQ      <= errD;
    end
  end

  assign Issue_ready_o = ready;
  assign Busy_o        = {busyQ[31:1], 1'b0};
  assign Inflight_o    = inflightQ;
  assign Err_o         = errQ;

endmodule

// File: tb/tb_riscv_regfile_scoreboard.sv
// Self-checking bench for riscv_regfile_scoreboard. A behavioural model predicts the
// next-state snapshot {Busy, Inflight, Err} whenever a cycle is driven; the prediction is
// queued and popped for comparison after the clock edge.
module tb_riscv_regfile_scoreboard;

  localparam int unsigned MaxInflight = 4;
  localparam bit          WbBypass    = 1'b1;

  typedef struct packed {
    logic [31:0] busy;
    logic [5:0]  inf;
    logic        err;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        issueValid;
  logic [4:0]  rs1, rs2, rd, wbRd;
  logic        rs1Used, rs2Used, rdWen;
  logic        issueReady;
  logic        wbValid;
  logic        flush;
  logic [31:0] busy;
  logic [5:0]  inflight;
  logic        err;

  logic [31:0] mBusy;
  logic [5:0]  mInf;
  logic        mErr;
  snap_t       expQ[$];
  snap_t       got, exp;
  int          nCmp = 0;
  int          nBad = 0;

  always #5 clk = ~clk;

  riscv_regfile_scoreboard #(
    .MAX_INFLIGHT(MaxInflight),
    .WB_BYPASS   (WbBypass)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .Issue_valid_i   (issueValid),
    .Issue_rs1_i     (rs1),
    .Issue_rs2_i     (rs2),
    .Issue_rs1_used_i(rs1Used),
    .Issue_rs2_used_i(rs2Used),
    .Issue_rd_i      (rd),
    .Issue_rd_wen_i  (rdWen),
    .Issue_ready_o   (issueReady),
    .Wb_valid_i      (wbValid),
    .Wb_rd_i         (wbRd),
    .Flush_i         (flush),
    .Busy_o          (busy),
    .Inflight_o      (inflight),
    .Err_o           (err)
  );

  function automatic snap_t snap();
    snap_t s;
    s.busy = busy;
    s.inf  = inflight;
    s.err  = err;
    return s;
  endfunction

  function automatic logic mEffBusy(input logic [4:0] r);
    return mBusy[r] & ~(WbBypass & wbValid & (wbRd == r) & (r != 5'd0));
  endfunction

  function automatic logic mReady();
    logic wbClr, haz;
    wbClr = wbValid && (wbRd != 5'd0) && mBusy[wbRd];
    haz   = (rs1Used && mEffBusy(rs1)) || (rs2Used && mEffBusy(rs2))
         || (rdWen && (rd != 5'd0) && mEffBusy(rd))
         || (rdWen && (rd != 5'd0) && (mInf == 6'(MaxInflight)) && !wbClr);
    return !flush && !haz;
  endfunction

  task automatic drive(input logic v, input logic [4:0] a, input logic ua, input logic [4:0] b,
                       input logic ub, input logic [4:0] d, input logic we, input logic wv,
                       input logic [4:0] wr, input logic fl);
    issueValid = v;  rs1 = a;  rs1Used = ua;  rs2 = b;  rs2Used = ub;
    rd = d;  rdWen = we;  wbValid = wv;  wbRd = wr;  flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Predict the post-edge state from the current inputs, queue it, advance one clock.
  task automatic stepClk();
    logic fire, wbClr;
    snap_t e;
    fire  = issueValid && mReady() && rdWen && (rd != 5'd0);
    wbClr = wbValid && (wbRd != 5'd0) && mBusy[wbRd];
    if (flush) begin
      mBusy = 32'd0;
      mInf  = 6'd0;
    end else begin
      if (wbValid && (wbRd != 5'd0) && !mBusy[wbRd]) mErr = 1'b1;
      if (wbClr) mBusy[wbRd] = 1'b0;
      if (fire)  mBusy[rd] = 1'b1;
      mInf = mInf + (fire ? 6'd1 : 6'd0) - (wbClr ? 6'd1 : 6'd0);
    end
    e.busy = mBusy;
    e.inf  = mInf;
    e.err  = mErr;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    mBusy = 32'd0;  mInf = 6'd0;  mErr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nCmp++;
    if (snap() !== snap_t'(0)) begin
      nBad++; $display("FAIL reset_state: got %h required 0", snap());
    end
    nCmp++;
    if (issueReady !== 1'b1) begin
      nBad++; $display("FAIL reset_ready: got %b required 1", issueReady);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_raw();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    nCmp++;
    if (issueReady !== 1'b1) begin
      nBad++; $display("FAIL raw_first_ready: got %b required 1", issueReady);
    end
    stepClk();
    got = snap(); exp = expQ.pop_front(); nCmp++;
    if (got !== exp || got.busy !== 32'h20 || got.inf !== 6'd1) begin
      nBad++; $display("FAIL raw_issue_x5: got %h required %h", got, exp);
    end
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    nCmp++;
    if (issueReady !== 1'b0) begin
      nBad++; $display("FAIL raw_stall: got %b required 0", issueReady);
    end
    stepClk();
    got = snap(); exp = expQ.pop_front(); nCmp++;
    if (got !== exp) begin
      nBad++; $display("FAIL raw_hold: got %h required %h", got, exp);
    end
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    #1;
    nCmp++;
    if (issueReady !== 1'b1) begin
      nBad++; $display("FAIL raw_bypass_ready: got %b required 1", issueReady);
    end
    stepClk();
    got = snap(); exp = expQ.pop_front(); nCmp++;
    if (got !== exp || got.busy !== 32'h0) begin
      nBad++; $display("FAIL raw_retire: got %h required %h", got, exp);
    end
  endtask

  task automatic test_max_inflight();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1, 1'b0, 5'd0, 1'b0);
      stepClk();
      got = snap(); exp = expQ.pop_front(); nCmp++;
      if (got !== exp) begin
        nBad++; $display("FAIL max_fill_%0d: got %h required %h", i, got, exp);
      end
    end
    nCmp++;
    if (inflight !== 6'd4) begin
      nBad++; $display("FAIL max_count: got %0d required 4", inflight);
    end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    nCmp++;
    if (issueReady !== 1'b0) begin
      nBad++; $display("FAIL max_stall: got %b required 0", issueReady);
    end
    drive(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    nCmp++;
    if (issueReady !== 1'b1) begin
      nBad++; $display("FAIL max_nowrite_ready: got %b required 1", issueReady);
    end
    stepClk();
    got = snap(); exp = expQ.pop_front(); nCmp++;
    if (got !== exp || got.inf !== 6'd4) begin
      nBad++; $display("FAIL max_nowrite_state: got %h required %h", got, exp);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'(i), 1'b0);
      stepClk();
      got = snap(); exp = expQ.pop_front(); nCmp++;
      if (got !== exp) begin
        nBad++; $display("FAIL max_drain_%0d: got %h required %h", i, got, exp);
      end
    end
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    stepClk();
    got = snap(); exp = expQ.pop_front(); nCmp++;
    if (got !== exp || got.busy !== 32'h0 || got.inf !== 6'd0) begin
      nBad++; $display("FAIL x0_issue: got %h required %h", got, exp);
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    stepClk();
    got = snap(); exp = expQ.pop_front(); nCmp++;
    if (got !== exp || got.err !== 1'b0) begin
      nBad++; $display("FAIL x0_wb_noerr: got %h required %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    stepClk();
    got = snap(); exp = expQ.pop_front(); nCmp++;
    if (got !== exp) begin
      nBad++; $display("FAIL b2b_first: got %h required %h", got, exp);
    end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
    #1;
    nCmp++;
    if (issueReady !== 1'b1) begin
      nBad++; $display("FAIL b2b_ready: got %b required 1", issueReady);
    end
    stepClk();
    got = snap(); exp = expQ.pop_front(); nCmp++;
    if (got !== exp || got.busy[7] !== 1'b1 || got.inf !== 6'd1 || got.err !== 1'b0) begin
      nBad++; $display("FAIL b2b_same_edge: got %h required %h", got, exp);
    end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    nCmp++;
    if (issueReady !== 1'b0) begin
      nBad++; $display("FAIL b2b_waw: got %b required 0", issueReady);
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    stepClk();
    got = snap(); exp = expQ.pop_front(); nCmp++;
    if (got !== exp || got.inf !== 6'd0) begin
      nBad++; $display("FAIL b2b_drain: got %h required %h", got, exp);
    end
  endtask

  task automatic test_err_flush();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
    stepClk();
    got = snap(); exp = expQ.pop_front(); nCmp++;
    if (got !== exp || got.err !== 1'b1) begin
      nBad++; $display("FAIL err_set: got %h required %h", got, exp);
    end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
    stepClk();
    got = snap(); exp = expQ.pop_front(); nCmp++;
    if (got !== exp || got.err !== 1'b1) begin
      nBad++; $display("FAIL err_sticky: got %h required %h", got, exp);
    end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1);
    #1;
    nCmp++;
    if (issueReady !== 1'b0) begin
      nBad++; $display("FAIL flush_ready: got %b required 0", issueReady);
    end
    stepClk();
    got = snap(); exp = expQ.pop_front(); nCmp++;
    if (got !== exp || got.busy !== 32'h0 || got.inf !== 6'd0 || got.err !== 1'b1) begin
      nBad++; $display("FAIL flush_state: got %h required %h", got, exp);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 11; i <= 13; i++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1, 1'b0, 5'd0, 1'b0);
      stepClk();
      got = snap(); exp = expQ.pop_front(); nCmp++;
      if (got !== exp) begin
        nBad++; $display("FAIL ar_fill_%0d: got %h required %h", i, got, exp);
      end
    end
    idle();
    #3;
    rst = 1'b1;
    #1;
    nCmp++;
    if (snap() !== snap_t'(0)) begin
      nBad++; $display("FAIL async_reset: got %h required 0", snap());
    end
    mBusy = 32'd0;  mInf = 6'd0;  mErr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0] r;
    for (int c = 0; c < 400; c++) begin
      r = 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), r,
            1'($urandom_range(0, 40) == 0));
      // Mostly retire registers that are actually busy to keep traffic flowing.
      if (wbValid && !mBusy[r] && ($urandom_range(0, 3) != 0)) begin
        for (int k = 1; k < 8; k++) if (mBusy[k]) wbRd = 5'(k);
      end
      #1;
      nCmp++;
      if (issueReady !== mReady()) begin
        nBad++; $display("FAIL rand_ready c%0d: got %b required %b", c, issueReady, mReady());
      end
      stepClk();
      got = snap(); exp = expQ.pop_front(); nCmp++;
      if (got !== exp) begin
        nBad++; $display("FAIL rand_state c%0d: got %h required %h", c, got, exp);
      end
      nCmp++;
      if (inflight !== 6'($countones(busy))) begin
        nBad++; $display("FAIL rand_popcount c%0d: got %0d required %0d", c, inflight,
                         $countones(busy));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_raw();
    test_max_inflight();
    test_x0();
    test_back_to_back();
    test_err_flush();
    test_async_reset();
    test_random();
    nCmp++;
    if (expQ.size() != 0) begin
      nBad++; $display("FAIL queue_empty: got %0d entries required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
